// File: rtl/program_loader_rom_if.sv
// Loader/fetch bus for program_loader_rom: loader handshake, fetch request and fetched word.
interface program_loader_rom_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              load_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_done;
  logic              fetch_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] prog;
  logic              prog_valid;
  logic              busy;

  modport master (
    output load_start, ld_valid, ld_data, ld_last, fetch_en, addr,
    input  ld_ready, ld_done, prog, prog_valid, busy
  );

  modport slave (
    input  load_start, ld_valid, ld_data, ld_last, fetch_en, addr,
    output ld_ready, ld_done, prog, prog_valid, busy
  );
endinterface

// File: rtl/program_loader_rom.sv
// Loadable program store: streamed in while in LOAD, read with one-cycle latency while in RUN.
module program_loader_rom #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  program_loader_rom_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] r_wptr;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_prog;
  logic [DATA_W-1:0] w_rd_data;
  logic              r_prog_valid;
  logic              r_ld_done;
  logic              w_beat;
  logic              w_end;
  logic              w_fetch;
  logic              w_start;

  assign w_beat  = (r_state == LOAD) && bus.ld_valid;
  assign w_end   = w_beat && (bus.ld_last || (r_wptr == LAST_ADDR));
  assign w_fetch = (r_state == RUN) && bus.fetch_en;
  // Restart requests are only honoured outside LOAD so a load cannot rewind itself.
  assign w_start = (r_state != LOAD) && bus.load_start;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.load_start) w_state_next = LOAD;
      LOAD:    if (w_end) w_state_next = RUN;
      RUN:     if (bus.load_start) w_state_next = LOAD;
      default: w_state_next = IDLE;
    endcase
  end

  // Out-of-range fetches read as zero rather than aliasing into the array.
  always_comb begin
    w_rd_data = '0;
    if ({1'b0, bus.addr} < DEPTH_W) w_rd_data = r_mem[bus.addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_beat) begin
      r_mem[r_wptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_wptr       <= '0;
      r_prog       <= '0;
      r_prog_valid <= 1'b0;
      r_ld_done    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_prog_valid <= w_fetch;
      r_ld_done    <= w_end;
      if (w_fetch) r_prog <= w_rd_data;
      if (w_start) begin
        r_wptr <= '0;
      end else if (w_beat) begin
        r_wptr <= r_wptr + 1'b1;
      end
    end
  end

  assign bus.ld_ready   = (r_state == LOAD);
  assign bus.busy       = (r_state == LOAD);
  assign bus.ld_done    = r_ld_done;
  assign bus.prog       = r_prog;
  assign bus.prog_valid = r_prog_valid;

endmodule

// File: doc/program_loader_rom.md
PROGRAM_LOADER_ROM -- requirements
Module: program_loader_rom

Interface
REQ-001 Parameter DATA_W, default 8: instruction word width in bits.
REQ-002 Parameter ADDR_W, default 4: program address width in bits.
REQ-003 Parameter DEPTH, default 16: number of words stored; legal range 2 to 2**ADDR_W.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low, synchronous deassert by the system.
REQ-006 Port load_start  input  1  request to enter load mode; sampled each cycle.
REQ-007 Port ld_valid  input  1  loader word valid.
REQ-008 Port ld_data  input  DATA_W  loader word.
REQ-009 Port ld_last  input  1  qualifies the final loader word; meaningful only with ld_valid.
REQ-010 Port ld_ready  output  1  block accepts a loader word this cycle.
REQ-011 Port ld_done  output  1  single-cycle pulse when a load completes.
REQ-012 Port fetch_en  input  1  fetch request in run mode.
REQ-013 Port addr  input  ADDR_W  fetch address.
REQ-014 Port prog  output  DATA_W  fetched instruction word (registered).
REQ-015 Port prog_valid  output  1  prog holds the word for the fetch issued the previous cycle.
REQ-016 Port busy  output  1  high while in LOAD state.

Function
REQ-017 The block SHALL implement states IDLE, LOAD, RUN; exactly one is active.
REQ-018 IDLE: ld_ready=0, prog_valid=0; load_start=1 -> LOAD next cycle with write pointer cleared to 0.
REQ-019 LOAD: ld_ready=1 and busy=1; fetch_en is ignored and prog_valid=0.
REQ-020 A beat transfers only when ld_valid=1 and ld_ready=1; mem[wptr] <= ld_data, wptr <= wptr+1.
REQ-021 LOAD SHALL end (-> RUN next cycle, ld_done=1 for that one cycle) on a beat with ld_last=1, or on the beat written to DEPTH-1, whichever comes first.
REQ-022 Locations not written during a load SHALL retain their previous contents.
REQ-023 load_start while in LOAD SHALL be ignored (no pointer restart).
REQ-024 RUN: fetch_en=1 -> prog <= mem[addr] and prog_valid=1 on the next cycle; latency exactly 1 cycle, back-to-back fetches sustain one word per cycle.
REQ-025 RUN: fetch_en=0 -> prog holds its last value, prog_valid=0 next cycle.
REQ-026 Fetch with addr >= DEPTH SHALL return all-zeros with prog_valid=1.
REQ-027 RUN: load_start=1 -> LOAD next cycle, wptr=0; a fetch issued in that same cycle SHALL still complete normally (prog_valid=1 once).
REQ-028 Simultaneous load_start and fetch_en in IDLE: load_start wins, no fetch performed.
REQ-029 ld_done and busy SHALL never be high in the same cycle.

Reset
REQ-030 On rst_n=0 the block SHALL immediately enter IDLE, wptr=0, ld_ready=0, ld_done=0, busy=0, prog=0, prog_valid=0.
REQ-031 Reset SHALL clear every memory location to 0.
REQ-032 Reset mid-load SHALL abort the load; no ld_done is issued and all contents read 0 afterwards.
REQ-033 First cycle after rst_n deasserts SHALL be IDLE regardless of inputs held during reset.

Verification
REQ-034 Reset, load_start, 16 beats 0x10..0x1F without ld_last -> ld_done pulse after beat 16, RUN; fetch addr 3 -> prog=0x13 next cycle, prog_valid=1.
REQ-035 Load 3 beats 0xA1,0xB2,0xC3 with ld_last on third -> fetch addrs 0,1,2,4 back-to-back -> 0xA1,0xB2,0xC3,0x00 on consecutive cycles.
REQ-036 ld_valid toggled with gaps during LOAD -> only valid cycles write; pointer advances per beat only.
REQ-037 In RUN, reload 2 beats 0x55,0x66 (ld_last on second) -> addr 0,1 read 0x55,0x66; addr 2 keeps prior value.
REQ-038 Assert rst_n=0 after 5 of 16 load beats -> outputs zero immediately, state IDLE, fetch after new load_start/ld_last reads 0 at untouched addresses.
REQ-039 DEPTH=10, ADDR_W=4 build: fetch addr 12 -> prog=0, prog_valid=1; load stops after 10th beat with ld_done.
